// File: rtl/bbox_pkg.sv
// Shared types, widths and helper functions for the bounding-box tracker.
package bbox_pkg;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;
  localparam int AREA_W   = 21;

  // One bounding box: extents on both axes plus mask-pixel count.
  typedef struct packed {
    logic [HCOUNT_W-1:0] x_min;
    logic [HCOUNT_W-1:0] x_max;
    logic [VCOUNT_W-1:0] y_min;
    logic [VCOUNT_W-1:0] y_max;
    logic [AREA_W-1:0]   area;
  } bbox_t;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    ACCUM  = 2'd1,
    COMMIT = 2'd2
  } trk_state_t;

  // Empty accumulator: min at all-ones and max at zero, so the first pixel wins both.
  function automatic bbox_t bbox_clear();
    bbox_t b;
    b.x_min = {HCOUNT_W{1'b1}};
    b.x_max = {HCOUNT_W{1'b0}};
    b.y_min = {VCOUNT_W{1'b1}};
    b.y_max = {VCOUNT_W{1'b0}};
    b.area  = {AREA_W{1'b0}};
    return b;
  endfunction

  // Accumulator holding exactly one pixel (first pixel of a new frame).
  function automatic bbox_t bbox_seed(input logic [HCOUNT_W-1:0] h,
                                      input logic [VCOUNT_W-1:0] v);
    bbox_t b;
    b.x_min = h;
    b.x_max = h;
    b.y_min = v;
    b.y_max = v;
    b.area  = {{(AREA_W-1){1'b0}}, 1'b1};
    return b;
  endfunction

  // Pixel count increment that sticks at all-ones instead of wrapping.
  function automatic logic [AREA_W-1:0] area_sat_inc(input logic [AREA_W-1:0] a);
    logic [AREA_W-1:0] r;
    if (&a) begin
      r = a;
    end else begin
      r = a + {{(AREA_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // Fold one pixel into a running box.
  function automatic bbox_t bbox_merge(input bbox_t b,
                                       input logic [HCOUNT_W-1:0] h,
                                       input logic [VCOUNT_W-1:0] v);
    bbox_t r;
    r = b;
    if (h < b.x_min) r.x_min = h; else r.x_min = b.x_min;
    if (h > b.x_max) r.x_max = h; else r.x_max = b.x_max;
    if (v < b.y_min) r.y_min = v; else r.y_min = b.y_min;
    if (v > b.y_max) r.y_max = v; else r.y_max = b.y_max;
    r.area = area_sat_inc(b.area);
    return r;
  endfunction

endpackage

// File: rtl/bbox_if.sv
// Pixel-stream input and committed-box result bundle of the tracker.
interface bbox_if;
  import bbox_pkg::*;

  logic [HCOUNT_W-1:0] hcount_in;
  logic [VCOUNT_W-1:0] vcount_in;
  logic                data_valid_in;
  logic                mask_in;
  logic                new_frame_in;

  logic                box_valid_out;
  logic [HCOUNT_W-1:0] x_min_out;
  logic [HCOUNT_W-1:0] x_max_out;
  logic [VCOUNT_W-1:0] y_min_out;
  logic [VCOUNT_W-1:0] y_max_out;
  logic [HCOUNT_W-1:0] x_center_out;
  logic [VCOUNT_W-1:0] y_center_out;
  logic [AREA_W-1:0]   area_out;
  logic                commit_out;
  logic                rect_pixel_out;

  // Video source / consumer side.
  modport master (
    output hcount_in, vcount_in, data_valid_in, mask_in, new_frame_in,
    input  box_valid_out, x_min_out, x_max_out, y_min_out, y_max_out,
    input  x_center_out, y_center_out, area_out, commit_out, rect_pixel_out
  );

  // Tracker side.
  modport slave (
    input  hcount_in, vcount_in, data_valid_in, mask_in, new_frame_in,
    output box_valid_out, x_min_out, x_max_out, y_min_out, y_max_out,
    output x_center_out, y_center_out, area_out, commit_out, rect_pixel_out
  );

endinterface

// File: rtl/bbox_overlay.sv
// Registered rectangle-outline comparator for the committed bounding box.
module bbox_overlay
  import bbox_pkg::*;
#(
  parameter int BORDER = 2
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  bbox_t               i_box,
  input  logic                i_box_valid,
  input  logic [HCOUNT_W-1:0] i_hcount,
  input  logic [VCOUNT_W-1:0] i_vcount,
  output logic                o_rect_pixel
);

  localparam logic [HCOUNT_W-1:0] BORDER_H = HCOUNT_W'(BORDER);
  localparam logic [VCOUNT_W-1:0] BORDER_V = VCOUNT_W'(BORDER);

  logic                w_in_x;
  logic                w_in_y;
  logic                w_nonempty;
  logic                w_on_edge;
  logic [HCOUNT_W-1:0] w_dx_lo;
  logic [HCOUNT_W-1:0] w_dx_hi;
  logic [VCOUNT_W-1:0] w_dy_lo;
  logic [VCOUNT_W-1:0] w_dy_hi;
  logic                r_rect;

  assign w_in_x     = (i_hcount >= i_box.x_min) && (i_hcount <= i_box.x_max);
  assign w_in_y     = (i_vcount >= i_box.y_min) && (i_vcount <= i_box.y_max);
  // An empty box never draws, even if it were flagged valid.
  assign w_nonempty = |i_box.area;

  // Distances are only meaningful once the pixel is known to be inside the box.
  assign w_dx_lo = i_hcount - i_box.x_min;
  assign w_dx_hi = i_box.x_max - i_hcount;
  assign w_dy_lo = i_vcount - i_box.y_min;
  assign w_dy_hi = i_box.y_max - i_vcount;

  assign w_on_edge = (w_dx_lo < BORDER_H) || (w_dx_hi < BORDER_H) ||
                     (w_dy_lo < BORDER_V) || (w_dy_hi < BORDER_V);

  // Register the outline decision for this cycle's coordinate.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rect <= 1'b0;
    end else begin
      r_rect <= i_box_valid & w_nonempty & w_in_x & w_in_y & w_on_edge;
    end
  end

  assign o_rect_pixel = r_rect;

endmodule

// File: rtl/bbox_tracker.sv
// Per-frame bounding-box / centroid tracker with outline overlay output.
module bbox_tracker
  import bbox_pkg::*;
#(
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int MIN_PIXELS = 64,
  parameter int BORDER     = 2
) (
  input  logic clk_in,
  input  logic rst_n_in,
  bbox_if.slave bus
);

  localparam logic [HCOUNT_W-1:0] H_LIM   = HCOUNT_W'(H_ACTIVE);
  localparam logic [VCOUNT_W-1:0] V_LIM   = VCOUNT_W'(V_ACTIVE);
  localparam logic [AREA_W-1:0]   MIN_CNT = AREA_W'(MIN_PIXELS);

  trk_state_t          r_state;
  bbox_t               r_acc;
  bbox_t               r_snap;
  bbox_t               r_box;
  logic                r_box_valid;
  logic                r_commit;
  logic [HCOUNT_W-1:0] r_x_center;
  logic [VCOUNT_W-1:0] r_y_center;

  logic                w_qual;
  bbox_t               w_merge;
  bbox_t               w_seed;
  logic [HCOUNT_W:0]   w_x_sum;
  logic [VCOUNT_W:0]   w_y_sum;
  logic                w_rect_pixel;

  assign w_qual = bus.data_valid_in & bus.mask_in &
                  (bus.hcount_in < H_LIM) & (bus.vcount_in < V_LIM);

  // Candidate accumulator values: this frame's running box, and a fresh
  // box for a frame starting this cycle (which owns any coincident pixel).
  always_comb begin
    w_merge = r_acc;
    w_seed  = bbox_clear();
    if (w_qual) begin
      w_merge = bbox_merge(r_acc, bus.hcount_in, bus.vcount_in);
      w_seed  = bbox_seed(bus.hcount_in, bus.vcount_in);
    end else begin
      w_merge = r_acc;
      w_seed  = bbox_clear();
    end
  end

  // One extra bit keeps the midpoint sum from overflowing.
  assign w_x_sum = {1'b0, r_snap.x_min} + {1'b0, r_snap.x_max};
  assign w_y_sum = {1'b0, r_snap.y_min} + {1'b0, r_snap.y_max};

  // Frame FSM: accumulate, snapshot at frame start, publish the snapshot a cycle later.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= WAIT;
      r_acc       <= bbox_clear();
      r_snap      <= bbox_clear();
      r_box       <= '0;
      r_box_valid <= 1'b0;
      r_commit    <= 1'b0;
      r_x_center  <= {HCOUNT_W{1'b0}};
      r_y_center  <= {VCOUNT_W{1'b0}};
    end else begin
      r_commit <= 1'b0;
      case (r_state)
        WAIT: begin
          // A partial frame is never reported: start counting at the next frame start.
          if (bus.new_frame_in) begin
            r_acc   <= w_seed;
            r_state <= ACCUM;
          end else begin
            r_acc   <= bbox_clear();
            r_state <= WAIT;
          end
        end
        ACCUM: begin
          if (bus.new_frame_in) begin
            r_snap  <= r_acc;
            r_acc   <= w_seed;
            r_state <= COMMIT;
          end else begin
            r_acc   <= w_merge;
            r_state <= ACCUM;
          end
        end
        COMMIT: begin
          r_box       <= r_snap;
          r_box_valid <= (r_snap.area >= MIN_CNT);
          r_x_center  <= w_x_sum[HCOUNT_W:1];
          r_y_center  <= w_y_sum[VCOUNT_W:1];
          r_commit    <= 1'b1;
          // A frame start here re-snapshots and publishes again next cycle.
          if (bus.new_frame_in) begin
            r_snap  <= r_acc;
            r_acc   <= w_seed;
            r_state <= COMMIT;
          end else begin
            r_acc   <= w_merge;
            r_state <= ACCUM;
          end
        end
        default: begin
          r_acc   <= bbox_clear();
          r_state <= WAIT;
        end
      endcase
    end
  end

  bbox_overlay #(
    .BORDER (BORDER)
  ) u_overlay (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .i_box        (r_box),
    .i_box_valid  (r_box_valid),
    .i_hcount     (bus.hcount_in),
    .i_vcount     (bus.vcount_in),
    .o_rect_pixel (w_rect_pixel)
  );

  assign bus.box_valid_out  = r_box_valid;
  assign bus.x_min_out      = r_box.x_min;
  assign bus.x_max_out      = r_box.x_max;
  assign bus.y_min_out      = r_box.y_min;
  assign bus.y_max_out      = r_box.y_max;
  assign bus.x_center_out   = r_x_center;
  assign bus.y_center_out   = r_y_center;
  assign bus.area_out       = r_box.area;
  assign bus.commit_out     = r_commit;
  assign bus.rect_pixel_out = w_rect_pixel;

endmodule
